fetch_ctrl: RTL and testbench

Instruction-fetch controller that sits directly downstream of the program counter register and upstream of decode. It reads the current PC, issues one instruction-memory request at a time, and buffers the returned word together with its address in a single-entry output stage. It drives the PC register's enable and next-value inputs for sequential advance, control-flow redirects and reset reload. At most one memory request is outstanding at any time.

---
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_fetch_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the PC register, keeps one imem request
// in flight, and buffers the returned word with its address for decode.
module fetch_ctrl #(
  parameter int                 WIDTH  = 16,
  parameter int                 IWIDTH = 16,
  parameter logic [WIDTH-1:0]   INIT   = '0,
  parameter int                 STEP   = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [WIDTH-1:0]  pc_q,
  output logic              pc_en,
  output logic [WIDTH-1:0]  pc_d,
  input  logic              redirect_valid,
  input  logic [WIDTH-1:0]  redirect_pc,
  output logic              imem_req_valid,
  output logic [WIDTH-1:0]  imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [IWIDTH-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [IWIDTH-1:0] inst_data,
  output logic [WIDTH-1:0]  inst_pc,
  input  logic              inst_ready,
  output logic [1:0]        dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready of the same channel except imem_req_valid on inst_ready.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                inst_valid_q, inst_valid_d;
  logic [IWIDTH-1:0]   inst_data_q, inst_data_d;
  logic [WIDTH-1:0]    inst_pc_q, inst_pc_d;
  logic [WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic                req_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_REQ;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
      fetch_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      fetch_pc_q   <= fetch_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    fetch_pc_d   = fetch_pc_q;
    pc_en        = 1'b0;
    pc_d         = pc_q;
    req_valid    = resetn && (state_q == ST_REQ) && !redirect_valid &&
                   (!inst_valid_q || inst_ready);

    if (inst_valid_q && inst_ready) begin
      inst_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      // Any response landing in a redirect cycle belongs to the old path.
      pc_en        = 1'b1;
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      case (state_q)
        ST_REQ:  state_d = ST_REQ;
        ST_WAIT: state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
        ST_DROP: state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (req_valid && imem_req_ready) begin
            fetch_pc_d = pc_q;
            pc_en      = 1'b1;
            pc_d       = pc_q + WIDTH'(STEP);
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            inst_data_d  = imem_rsp_data;
            inst_pc_d    = fetch_pc_q;
            inst_valid_d = 1'b1;
            state_d      = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_rsp_valid) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end

    if (!resetn) begin
      pc_en = 1'b1;
      pc_d  = INIT;
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC register model and a delay-programmable
// instruction memory that returns 0xA000 + (addr - 0x0100).
module tb_fetch_ctrl;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [15:0] INIT_PC = 16'h0100;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] pc_reg;
  logic        pc_en;
  logic [15:0] pc_d;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req_valid;
  logic [15:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid = 1'b0;
  logic [15:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl #(.WIDTH(16), .IWIDTH(16), .INIT(INIT_PC), .STEP(1)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .pc_q           (pc_reg),
    .pc_en          (pc_en),
    .pc_d           (pc_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .dbg_state_o    (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // PC register owned by the environment
  always @(posedge clk) begin
    if (pc_en) pc_reg <= pc_d;
  end

  // Instruction memory: accepts on the edge, answers rsp_delay cycles later
  int          rsp_delay = 1;
  bit          mem_pend  = 1'b0;
  int          mem_cnt   = 0;
  logic [15:0] mem_addr  = '0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 + (a - 16'h0100);
  endfunction

  always @(posedge clk) begin
    if (resetn && imem_req_valid && imem_req_ready) begin
      mem_pend = 1'b1;
      mem_cnt  = rsp_delay - 1;
      mem_addr = imem_req_addr;
    end
  end

  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_pend       = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver: advance to the middle of the next cycle, after inputs settle
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      next_cycle(); settle();
      check_eq("rst_pc_en", pc_en, 1);
      check_eq("rst_pc_d", pc_d, INIT_PC);
      check_eq("rst_req_valid", imem_req_valid, 0);
      check_eq("rst_inst_valid", inst_valid, 0);
      check_eq("rst_state", dbg_state, S_REQ);
    end

    // First request right after release
    next_cycle();
    resetn = 1'b1; inst_ready = 1'b1;
    settle();
    check_eq("first_req_valid", imem_req_valid, 1);
    check_eq("first_req_addr", imem_req_addr, 16'h0100);
    check_eq("first_pc_d", pc_d, 16'h0101);

    // Zero-wait stream, one instruction per two cycles
    for (int k = 0; k < 3; k++) begin
      next_cycle(); settle();
      check_eq("stream_wait_state", dbg_state, S_WAIT);
      check_eq("stream_rsp_seen", imem_rsp_valid, 1);
      check_eq("stream_no_req", imem_req_valid, 0);
      check_eq("stream_pc_adv", pc_reg, 16'h0101 + 16'(k));
      next_cycle();
      if (k == 2) inst_ready = 1'b0;
      settle();
      check_eq("stream_inst_valid", inst_valid, 1);
      check_eq("stream_inst_pc", inst_pc, 16'h0100 + 16'(k));
      check_eq("stream_inst_data", inst_data, 16'hA000 + 16'(k));
      if (k < 2) begin
        check_eq("stream_req_valid", imem_req_valid, 1);
        check_eq("stream_req_addr", imem_req_addr, 16'h0101 + 16'(k));
      end else begin
        check_eq("stall_req_blocked", imem_req_valid, 0);
      end
    end

    // Buffer full, decode stalled: remaining stall cycles
    for (int i = 0; i < 4; i++) begin
      next_cycle(); settle();
      check_eq("stall_req_blocked", imem_req_valid, 0);
      check_eq("stall_inst_valid", inst_valid, 1);
      check_eq("stall_inst_data", inst_data, 16'hA002);
    end

    // Release: request goes out in the same cycle; slow response follows
    next_cycle();
    inst_ready = 1'b1; rsp_delay = 4;
    settle();
    check_eq("release_req_valid", imem_req_valid, 1);
    check_eq("release_req_addr", imem_req_addr, 16'h0103);

    // Redirect while WAIT, response three cycles later is dropped
    next_cycle();
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    settle();
    check_eq("redir_wait_state", dbg_state, S_WAIT);
    check_eq("redir_pc_en", pc_en, 1);
    check_eq("redir_pc_d", pc_d, 16'h0200);
    check_eq("redir_no_req", imem_req_valid, 0);
    check_eq("redir_consumed", inst_valid, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      redirect_valid = 1'b0;
      settle();
      check_eq("drop_state", dbg_state, S_DROP);
      check_eq("drop_no_req", imem_req_valid, 0);
      check_eq("drop_rsp_at", imem_rsp_valid, (i == 2) ? 1 : 0);
    end
    next_cycle();
    rsp_delay = 1;
    settle();
    check_eq("after_drop_state", dbg_state, S_REQ);
    check_eq("after_drop_inst_valid", inst_valid, 0);
    check_eq("after_drop_pc", pc_reg, 16'h0200);
    check_eq("after_drop_req_valid", imem_req_valid, 1);
    check_eq("after_drop_req_addr", imem_req_addr, 16'h0200);

    // Redirect coincident with the response in WAIT
    next_cycle();
    redirect_valid = 1'b1; redirect_pc = 16'h0300;
    settle();
    check_eq("coinc_state", dbg_state, S_WAIT);
    check_eq("coinc_rsp", imem_rsp_valid, 1);
    check_eq("coinc_pc_d", pc_d, 16'h0300);
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    check_eq("coinc_after_state", dbg_state, S_REQ);
    check_eq("coinc_discarded", inst_valid, 0);
    check_eq("coinc_req_valid", imem_req_valid, 1);
    check_eq("coinc_req_addr", imem_req_addr, 16'h0300);
    next_cycle(); settle();
    check_eq("target_wait", dbg_state, S_WAIT);
    next_cycle();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    settle();
    check_eq("target_inst_pc", inst_pc, 16'h0300);
    check_eq("target_inst_data", inst_data, 16'hA200);
    check_eq("target_inst_valid", inst_valid, 1);

    // PC wrap at 0xFFFF
    next_cycle();
    redirect_valid = 1'b0; rsp_delay = 3;
    settle();
    check_eq("wrap_req_addr", imem_req_addr, 16'hFFFF);
    check_eq("wrap_req_valid", imem_req_valid, 1);
    check_eq("wrap_pc_d", pc_d, 16'h0000);
    next_cycle(); settle();
    check_eq("wrap_pc_q", pc_reg, 16'h0000);
    check_eq("wrap_wait", dbg_state, S_WAIT);

    // Reset in WAIT; the late response lands during reset
    next_cycle();
    resetn = 1'b0;
    settle();
    check_eq("midrst_pc_d", pc_d, INIT_PC);
    check_eq("midrst_no_req", imem_req_valid, 0);
    next_cycle(); settle();
    check_eq("midrst_state", dbg_state, S_REQ);
    check_eq("midrst_late_rsp", imem_rsp_valid, 1);
    next_cycle();
    resetn = 1'b1;
    settle();
    check_eq("postrst_inst_valid", inst_valid, 0);
    check_eq("postrst_pc", pc_reg, INIT_PC);
    check_eq("postrst_req_valid", imem_req_valid, 1);
    check_eq("postrst_req_addr", imem_req_addr, INIT_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
